// File: rtl/gamma_mapper_loader.sv
// Gamma mapper table loader: buffers host bytes and sequences mapperconf writes.
// Optional GAMMA_MAPPER_LOADER_CHECKSUM_EN adds a per-load byte checksum output.

`ifndef MAPPER_CONF_RED
`define MAPPER_CONF_RED 8'h01
`endif
`ifndef MAPPER_CONF_GREEN
`define MAPPER_CONF_GREEN 8'h02
`endif
`ifndef MAPPER_CONF_BLUE
`define MAPPER_CONF_BLUE 8'h03
`endif

module gamma_mapper_loader #(
    parameter int HOLD_CYCLES = 2,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_channel,
    input  logic [7:0]  cmd_start,
    input  logic [7:0]  cmd_count,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    input  logic        abort,
    output logic [23:0] mapperconf,
    output logic        busy,
    output logic        done
`ifdef GAMMA_MAPPER_LOADER_CHECKSUM_EN
    ,
    output logic [15:0] checksum
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(FIFO_DEPTH);
    localparam logic [3:0] HOLD_M1 = 4'(HOLD_CYCLES - 1);
    localparam logic [7:0] CONF_RED = `MAPPER_CONF_RED;
    localparam logic [7:0] CONF_GREEN = `MAPPER_CONF_GREEN;
    localparam logic [7:0] CONF_BLUE = `MAPPER_CONF_BLUE;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EMIT,
        FINISH
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  chan_q, chan_d;
    logic [7:0]  pos_q, pos_d;
    logic [8:0]  rem_q, rem_d;
    logic [7:0]  data_q, data_d;
    logic [1:0]  sub_q, sub_d;
    logic [3:0]  hold_q, hold_d;
    logic [23:0] conf_q, conf_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   cnt_q, cnt_d;
`ifdef GAMMA_MAPPER_LOADER_CHECKSUM_EN
    logic [15:0] sum_q, sum_d;
`endif

    logic [7:0] fifo_mem [FIFO_DEPTH];
    logic [7:0] head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       push;
    logic       pop;
    logic       flush;
    logic [1:0] sub_first;
    logic [1:0] sub_next;

    function automatic logic [7:0] conf_code(input logic [1:0] s);
        case (s)
            2'd1:    return CONF_RED;
            2'd2:    return CONF_GREEN;
            2'd3:    return CONF_BLUE;
            default: return 8'h00;
        endcase
    endfunction

    assign head       = fifo_mem[rptr_q];
    assign fifo_full  = (cnt_q == DEPTH_W);
    assign fifo_empty = (cnt_q == '0);
    assign in_ready   = busy_q & ~fifo_full;
    assign push       = in_valid & in_ready;
    assign sub_first  = (chan_q == 2'd0) ? 2'd1 : chan_q;
    assign sub_next   = sub_q + 2'd1;
    assign cmd_ready  = (state_q == IDLE);
    assign mapperconf = conf_q;
    assign busy       = busy_q;
    assign done       = done_q;
`ifdef GAMMA_MAPPER_LOADER_CHECKSUM_EN
    assign checksum   = sum_q;
`endif

    // Next-state logic: command accept, byte fetch, word hold/sequence, finish, abort.
    always_comb begin
        state_d = state_q;
        chan_d  = chan_q;
        pos_d   = pos_q;
        rem_d   = rem_q;
        data_d  = data_q;
        sub_d   = sub_q;
        hold_d  = hold_q;
        conf_d  = conf_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pop     = 1'b0;
        flush   = 1'b0;
`ifdef GAMMA_MAPPER_LOADER_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    chan_d  = cmd_channel;
                    pos_d   = cmd_start;
                    rem_d   = (cmd_count == 8'd0) ? 9'd256 : {1'b0, cmd_count};
                    busy_d  = 1'b1;
                    state_d = FETCH;
`ifdef GAMMA_MAPPER_LOADER_CHECKSUM_EN
                    sum_d   = 16'h0000;
`endif
                end
            end
            FETCH: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    data_d  = head;
                    sub_d   = sub_first;
                    hold_d  = HOLD_M1;
                    conf_d  = {conf_code(sub_first), pos_q, head};
                    state_d = EMIT;
`ifdef GAMMA_MAPPER_LOADER_CHECKSUM_EN
                    sum_d   = sum_q + {8'h00, head};
`endif
                end
            end
            EMIT: begin
                if (hold_q != 4'd0) begin
                    hold_d = hold_q - 4'd1;
                end else if (chan_q == 2'd0 && sub_q != 2'd3) begin
                    sub_d  = sub_next;
                    hold_d = HOLD_M1;
                    conf_d = {conf_code(sub_next), pos_q, data_q};
                end else begin
                    conf_d  = 24'h000000;
                    pos_d   = pos_q + 8'd1;
                    rem_d   = rem_q - 9'd1;
                    state_d = (rem_q == 9'd1) ? FINISH : FETCH;
                end
            end
            FINISH: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                flush   = 1'b1;
                state_d = IDLE;
            end
        endcase
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            conf_d  = 24'h000000;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            pop     = 1'b0;
            flush   = 1'b1;
`ifdef GAMMA_MAPPER_LOADER_CHECKSUM_EN
            sum_d   = sum_q;
`endif
        end
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            wptr_d = wptr_q + AW'(push);
            rptr_d = rptr_q + AW'(pop);
            cnt_d  = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // Control, output and FIFO pointer registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            chan_q  <= 2'd0;
            pos_q   <= 8'd0;
            rem_q   <= 9'd0;
            data_q  <= 8'd0;
            sub_q   <= 2'd0;
            hold_q  <= 4'd0;
            conf_q  <= 24'h000000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
`ifdef GAMMA_MAPPER_LOADER_CHECKSUM_EN
            sum_q   <= 16'h0000;
`endif
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            pos_q   <= pos_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            sub_q   <= sub_d;
            hold_q  <= hold_d;
            conf_q  <= conf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
`ifdef GAMMA_MAPPER_LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    // Byte storage; contents need no reset since pointers define validity.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wptr_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_gamma_mapper_loader.sv
// Directed bench for gamma_mapper_loader (HOLD_CYCLES=2, FIFO_DEPTH=4).
// Checks reset, single/mode-0 loads, wrap + 256 count, backpressure, abort.

`ifndef MAPPER_CONF_RED
`define MAPPER_CONF_RED 8'h01
`endif
`ifndef MAPPER_CONF_GREEN
`define MAPPER_CONF_GREEN 8'h02
`endif
`ifndef MAPPER_CONF_BLUE
`define MAPPER_CONF_BLUE 8'h03
`endif

module tb_gamma_mapper_loader;

    localparam logic [7:0] RED = `MAPPER_CONF_RED;
    localparam logic [7:0] GRN = `MAPPER_CONF_GREEN;
    localparam logic [7:0] BLU = `MAPPER_CONF_BLUE;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_channel = 2'd0;
    logic [7:0]  cmd_start = 8'd0;
    logic [7:0]  cmd_count = 8'd0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready;
    logic        abort = 1'b0;
    logic [23:0] mapperconf;
    logic        busy;
    logic        done;
`ifdef GAMMA_MAPPER_LOADER_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    int tests = 0;
    int fails = 0;
    int stall_cnt = 0;
    logic [7:0]  src_q[$];
    logic [23:0] tr[$];
    logic        dn[$];
    logic [23:0] exp_q[$];

    always #5 clock = ~clock;

    gamma_mapper_loader #(
        .HOLD_CYCLES(2),
        .FIFO_DEPTH(4)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_channel(cmd_channel),
        .cmd_start(cmd_start),
        .cmd_count(cmd_count),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .abort(abort),
        .mapperconf(mapperconf),
        .busy(busy),
        .done(done)
`ifdef GAMMA_MAPPER_LOADER_CHECKSUM_EN
        ,
        .checksum(checksum)
`endif
    );

    // Called at a negedge: present command for one cycle.
    task automatic send_cmd(input logic [1:0] ch, input logic [7:0] st,
                            input logic [7:0] cnt);
        cmd_valid = 1'b1;
        cmd_channel = ch;
        cmd_start = st;
        cmd_count = cnt;
        @(negedge clock);
        cmd_valid = 1'b0;
    endtask

    // Push src_q bytes; in_ready is register-driven so it is stable here.
    task automatic feed();
        int idx = 0;
        int guard = 0;
        logic acc;
        while (idx < src_q.size() && guard < 3000) begin
            in_valid = 1'b1;
            in_data = src_q[idx];
            acc = in_ready;
            @(negedge clock);
            guard++;
            if (acc) idx++;
            else stall_cnt++;
        end
        in_valid = 1'b0;
    endtask

    task automatic capture(input int maxc);
        tr.delete();
        dn.delete();
        for (int c = 0; c < maxc; c++) begin
            @(negedge clock);
            tr.push_back(mapperconf);
            dn.push_back(done);
            if (done === 1'b1) break;
        end
    endtask

    function automatic int first_word();
        for (int i = 0; i < tr.size(); i++)
            if (tr[i] !== 24'h0) return i;
        return -1;
    endfunction

    // Returns -1 when trace equals exp_q followed by exactly one done cycle.
    function automatic int trace_diff();
        int f = first_word();
        if (f < 0) return 0;
        for (int k = 0; k < exp_q.size(); k++)
            if (f + k >= tr.size() || tr[f+k] !== exp_q[k]) return k;
        if (tr.size() != f + exp_q.size() + 1) return exp_q.size();
        if (dn[f+exp_q.size()] !== 1'b1) return exp_q.size();
        return -1;
    endfunction

    function automatic logic [23:0] got_at(input int k);
        int f = first_word();
        if (f < 0 || f + k >= tr.size()) return 24'hxxxxxx;
        return tr[f+k];
    endfunction

    function automatic logic [23:0] want_at(input int k);
        if (k < exp_q.size()) return exp_q[k];
        return 24'h000000;
    endfunction

    task automatic add_entry(input logic [1:0] ch, input logic [7:0] p,
                             input logic [7:0] d);
        if (ch == 2'd0) begin
            exp_q.push_back({RED, p, d});
            exp_q.push_back({RED, p, d});
            exp_q.push_back({GRN, p, d});
            exp_q.push_back({GRN, p, d});
            exp_q.push_back({BLU, p, d});
            exp_q.push_back({BLU, p, d});
        end else begin
            exp_q.push_back({(ch == 2'd1) ? RED : (ch == 2'd2) ? GRN : BLU, p, d});
            exp_q.push_back({(ch == 2'd1) ? RED : (ch == 2'd2) ? GRN : BLU, p, d});
        end
        exp_q.push_back(24'h000000);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        tests++;
        if (mapperconf !== 24'h0) begin
            fails++;
            $display("FAIL reset_conf: got %h want 000000", mapperconf);
        end
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_busy_done: got %b%b want 00", busy, done);
        end
        tests++;
        if (cmd_ready !== 1'b1 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_ready: got cmd %b in %b want 1 0", cmd_ready, in_ready);
        end
    endtask

    task automatic test_single();
        int d;
        send_cmd(2'd1, 8'h20, 8'd1);
        tests++;
        if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
            fails++;
            $display("FAIL single_accept: got busy %b cmd_ready %b want 1 0", busy, cmd_ready);
        end
        src_q = '{8'hA5};
        exp_q.delete();
        add_entry(2'd1, 8'h20, 8'hA5);
        fork
            feed();
            capture(60);
        join
        d = trace_diff();
        tests++;
        if (d !== -1) begin
            fails++;
            $display("FAIL single_trace: idx %0d got %h want %h", d, got_at(d), want_at(d));
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL single_busy_at_done: got %b want 0", busy);
        end
        @(negedge clock);
        tests++;
        if (done !== 1'b0 || cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL single_done_pulse: got done %b cmd_ready %b want 0 1", done, cmd_ready);
        end
    endtask

    task automatic test_mode0();
        int d;
        send_cmd(2'd0, 8'h05, 8'd2);
        src_q = '{8'h11, 8'h22};
        exp_q.delete();
        add_entry(2'd0, 8'h05, 8'h11);
        add_entry(2'd0, 8'h06, 8'h22);
        fork
            feed();
            capture(80);
        join
        d = trace_diff();
        tests++;
        if (d !== -1) begin
            fails++;
            $display("FAIL mode0_trace: idx %0d got %h want %h", d, got_at(d), want_at(d));
        end
`ifdef GAMMA_MAPPER_LOADER_CHECKSUM_EN
        tests++;
        if (checksum !== 16'h0033) begin
            fails++;
            $display("FAIL mode0_checksum: got %h want 0033", checksum);
        end
`endif
        @(negedge clock);
    endtask

    task automatic test_wrap256();
        int d;
        send_cmd(2'd3, 8'hFE, 8'd0);
        src_q.delete();
        exp_q.delete();
        for (int i = 0; i < 256; i++) begin
            src_q.push_back(8'(i));
            add_entry(2'd3, 8'(8'hFE + i), 8'(i));
        end
        fork
            feed();
            capture(2000);
        join
        d = trace_diff();
        tests++;
        if (d !== -1) begin
            fails++;
            $display("FAIL wrap256_trace: idx %0d got %h want %h", d, got_at(d), want_at(d));
        end
`ifdef GAMMA_MAPPER_LOADER_CHECKSUM_EN
        tests++;
        if (checksum !== 16'h7F80) begin
            fails++;
            $display("FAIL wrap256_checksum: got %h want 7f80", checksum);
        end
`endif
        @(negedge clock);
        tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL wrap256_single_done: got done %b busy %b want 0 0", done, busy);
        end
    endtask

    task automatic test_backpressure();
        int d;
        stall_cnt = 0;
        send_cmd(2'd2, 8'h30, 8'd8);
        src_q = '{8'hC1, 8'h3C, 8'h5A, 8'hA5, 8'h0F, 8'hF0, 8'h99, 8'h66};
        exp_q.delete();
        for (int i = 0; i < 8; i++)
            add_entry(2'd2, 8'(8'h30 + i), src_q[i]);
        fork
            feed();
            capture(200);
        join
        d = trace_diff();
        tests++;
        if (d !== -1) begin
            fails++;
            $display("FAIL backpressure_order: idx %0d got %h want %h", d, got_at(d), want_at(d));
        end
        tests++;
        if (stall_cnt == 0) begin
            fails++;
            $display("FAIL backpressure_stall: got %0d stalled cycles want >0", stall_cnt);
        end
        @(negedge clock);
    endtask

    task automatic test_abort();
        int d;
        bit seen = 1'b0;
        send_cmd(2'd1, 8'h50, 8'd10);
        src_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        fork
            feed();
            begin
                for (int c = 0; c < 100 && !seen; c++) begin
                    @(negedge clock);
                    if (mapperconf === {RED, 8'h52, 8'hA2}) seen = 1'b1;
                end
            end
        join
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL abort_wait: got no third word want %h", {RED, 8'h52, 8'hA2});
        end
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        tests++;
        if (mapperconf !== 24'h0 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL abort_state: got conf %h busy %b done %b want 000000 0 0",
                     mapperconf, busy, done);
        end
        tests++;
        if (cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL abort_cmd_ready: got %b want 1", cmd_ready);
        end
`ifdef GAMMA_MAPPER_LOADER_CHECKSUM_EN
        tests++;
        if (checksum !== 16'h01E3) begin
            fails++;
            $display("FAIL abort_checksum: got %h want 01e3", checksum);
        end
`endif
        send_cmd(2'd1, 8'h60, 8'd1);
        src_q = '{8'h77};
        exp_q.delete();
        add_entry(2'd1, 8'h60, 8'h77);
        fork
            feed();
            capture(60);
        join
        d = trace_diff();
        tests++;
        if (d !== -1) begin
            fails++;
            $display("FAIL abort_flush_next: idx %0d got %h want %h", d, got_at(d), want_at(d));
        end
        @(negedge clock);
    endtask

    task automatic test_reset_mid_emit();
        int d;
        bit seen = 1'b0;
        send_cmd(2'd1, 8'h10, 8'd1);
        src_q = '{8'h55, 8'h99};
        fork
            feed();
            begin
                for (int c = 0; c < 100 && !seen; c++) begin
                    @(negedge clock);
                    if (mapperconf === {RED, 8'h10, 8'h55}) seen = 1'b1;
                end
            end
        join
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL rst_emit_wait: got no word want %h", {RED, 8'h10, 8'h55});
        end
        #2 reset_n = 1'b0;
        #1;
        tests++;
        if (mapperconf !== 24'h0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL rst_emit_async: got conf %h busy %b want 000000 0", mapperconf, busy);
        end
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        tests++;
        if (cmd_ready !== 1'b1 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL rst_emit_release: got cmd %b in %b want 1 0", cmd_ready, in_ready);
        end
        send_cmd(2'd1, 8'h12, 8'd1);
        src_q = '{8'h66};
        exp_q.delete();
        add_entry(2'd1, 8'h12, 8'h66);
        fork
            feed();
            capture(60);
        join
        d = trace_diff();
        tests++;
        if (d !== -1) begin
            fails++;
            $display("FAIL rst_emit_fifo_empty: idx %0d got %h want %h", d, got_at(d), want_at(d));
        end
        @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_single();
        test_mode0();
        test_wrap256();
        test_backpressure();
        test_abort();
        test_reset_mid_emit();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gamma_mapper_loader.md
Name: gamma_mapper_loader

Overview:
- Write-side driver for the gamma mapper table update port.
- Takes a table-load command and a stream of mapping bytes from the host-side control path.
- Buffers the bytes and sequences them onto the 24-bit mapperconf bus as {conf, position, data} words.
- Each word is held stable long enough for the registered mapper update logic to capture it. The loader sits in the preproc clock domain next to the gamma conversion stage.

Parameters:
- HOLD_CYCLES, 2: cycles each mapperconf write word is driven; legal range 1..15.
- FIFO_DEPTH, 16: data byte buffer depth; power of two, 4..64.

Ports:
- clock  in  1  single system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  load command present.
- cmd_ready  out  1  high only in IDLE.
- cmd_channel  in  2  0=all three, 1=red, 2=green, 3=blue.
- cmd_start  in  8  first table position.
- cmd_count  in  8  number of entries; 0 means 256.
- in_valid  in  1  data byte present.
- in_data  in  8  mapping value.
- in_ready  out  1  equals busy AND NOT fifo_full.
- abort  in  1  cancel the current load.
- mapperconf  out  24  {conf[23:16], pos[15:8], data[7:0]}.
- busy  out  1  high from command accept until return to IDLE.
- done  out  1  one-cycle pulse on normal completion.

Behaviour:
- Reset (asynchronous, reset_n low):
  - mapperconf=24'h000000, busy=0, done=0, cmd_ready=1 after release.
  - FIFO emptied; state=IDLE.
- Conf codes:
  - Red/green/blue use `MAPPER_CONF_RED/GREEN/BLUE from config.inc.
  - Idle word is conf 8'h00, which matches no channel. pos and data are also 0 while idle.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch channel, pos=cmd_start, remaining = (cmd_count==0 ? 256 : cmd_count). Set busy=1 the next cycle and go to FETCH.
  - Input bytes are not accepted (in_ready=0).
- FETCH:
  - If FIFO is non-empty: pop one byte into a data register, set sub-channel (red if mode 0, else the selected channel), go to EMIT.
  - If empty: stay, drive the idle word.
- EMIT:
  - mapperconf = {code(sub), pos, data}, registered, for exactly HOLD_CYCLES cycles.
  - Mode 0 sequence: R then G then B, each HOLD_CYCLES, with no idle gap between them.
  - After the final sub-word: pos <= pos+1 (wraps 255->0), remaining--.
  - If remaining becomes 0, go to FINISH; else go to FETCH.
  - Latency: a byte popped on cycle t appears on mapperconf at t+1.
  - Back-to-back: if the FIFO is non-empty, FETCH lasts 1 cycle, during which the idle word is driven.
- FINISH:
  - Drive the idle word for 1 cycle, pulse done, clear busy, go to IDLE.
- FIFO:
  - Write on in_valid AND in_ready.
  - Simultaneous push and pop are allowed when full; in_ready still reflects full before the pop.
  - Bytes in excess of remaining are left in the FIFO and flushed on return to IDLE.
- abort (any non-IDLE state):
  - Next cycle: mapperconf = idle word, FIFO flushed, busy=0, no done pulse, state IDLE.
  - Table entries already written remain.
  - abort in IDLE is ignored.
- cmd_valid while busy: ignored; cmd_ready=0.

Optional Feature:
- Macro: GAMMA_MAPPER_LOADER_CHECKSUM_EN.
- When defined, adds output checksum [15:0]:
  - Modular sum of all data bytes popped during the current load, zero-extended.
  - Cleared on command accept.
  - Valid and stable from the done pulse until the next command accept.
  - In mode 0, each byte is counted once.
  - Abort leaves the partial sum.
- When undefined: no port, no adder logic.

Test Plan:
- Reset mid-EMIT (mode 1, HOLD_CYCLES=2, byte 8'h55 at pos 8'h10), assert reset_n=0 -> mapperconf=0 immediately, busy=0; after release, cmd_ready=1 and FIFO empty.
- Single red entry: cmd_channel=1, start=8'h20, count=1, byte 8'hA5 -> mapperconf={RED,8'h20,8'hA5} for exactly 2 cycles, then idle 1 cycle, done pulse; busy falls with done.
- Mode 0: start=8'h05, count=2, bytes 8'h11, 8'h22 -> R/G/B words at pos 05 with data 11, each held 2 cycles; one idle cycle; then R/G/B at pos 06 with data 22; done.
- Wrap and 256 count: cmd_channel=3, start=8'hFE, count=0, bytes 0..255 -> blue positions FE, FF, 00, ..., FD; 256 writes; one done pulse. Checksum build: checksum=16'h7F80.
- Backpressure: FIFO_DEPTH=4, push 8 bytes continuously -> in_ready low while 4 bytes are held; no byte lost or duplicated; output order matches input order.
- Abort: count=10, abort after the 3rd word -> idle word the next cycle, no done, busy=0, FIFO empty; a new command is accepted the following cycle.
